// File: rtl/if_id_buffer_pkg.sv
// ----------------------------------------------------------------------------
// if_id_buffer_pkg
// Shared constants for the IF/ID boundary.
//  - WORD_WIDTH     : instruction width used by fetch and decode
//  - MEM_ADDR_WIDTH : program-counter width
//  - NOP_INST       : ADDI x0,x0,0. The fetch stage reuses this value, so
//                     both sides of the boundary agree on what a bubble is.
//  - ptrNext        : advance a 1-bit ring pointer of the 2-entry buffer
// ----------------------------------------------------------------------------
package if_id_buffer_pkg;

   localparam int WORD_WIDTH     = 32;
   localparam int MEM_ADDR_WIDTH = 32;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam logic [1:0] BUF_DEPTH = 2'd2;

   // With two slots the pointer is a single bit, so "advance and wrap
   // 1 -> 0" is just an inversion.
   function automatic logic ptrNext(input logic ptr);
      return ~ptr;
   endfunction

endpackage

// File: rtl/if_id_buffer.sv
// ----------------------------------------------------------------------------
// if_id_buffer
// Two-entry in-order FIFO of {instruction, PC} pairs between fetch and decode.
//
// Ports
//  clk       in   rising-edge clock
//  rst       in   synchronous active-high reset
//  flush     in   drop all buffered entries (taken branch / jump)
//  in_valid  in   fetch presents an instruction
//  in_inst   in   fetched instruction
//  in_pc     in   PC of in_inst
//  in_ready  out  buffer has a free slot (fetch stalls its PC when low)
//  out_valid out  head entry valid for decode
//  out_inst  out  head instruction, NOP when empty
//  out_pc    out  head PC, 0 when empty
//  out_ready in   decode takes the head entry this cycle
//  count     out  occupancy, 0..2
// ----------------------------------------------------------------------------
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int addr_width = MEM_ADDR_WIDTH,
   parameter int word_width = WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [word_width-1:0] in_inst,
   input  logic [addr_width-1:0] in_pc,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [word_width-1:0] out_inst,
   output logic [addr_width-1:0] out_pc,
   input  logic                  out_ready,
   output logic [1:0]            count
);

   logic [word_width-1:0] r_instMem [2];
   logic [addr_width-1:0] r_pcMem   [2];
   logic                  r_wrPtr;
   logic                  r_rdPtr;
   logic [1:0]            r_count;

   logic                  w_inReady;
   logic                  w_outValid;
   logic                  w_enq;
   logic                  w_deq;

   // Handshake qualifiers. in_ready looks only at registered occupancy, so
   // a full buffer refuses input even when decode drains it this same cycle;
   // that keeps out_ready off the fetch stall path. flush suppresses both
   // transfers.
   always_comb begin
      w_inReady  = (r_count != BUF_DEPTH);
      w_outValid = (r_count != 2'd0);
      w_enq      = in_valid   & w_inReady & ~flush;
      w_deq      = w_outValid & out_ready & ~flush;
   end

   // Occupancy and both pointers live together so reset, flush and the
   // enqueue/dequeue combinations resolve in one priority chain. Reset beats
   // flush, flush beats any transfer. Simultaneous enqueue and dequeue moves
   // both pointers and leaves the count alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 2'd0;
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
      end else if (flush) begin
         r_count <= 2'd0;
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
      end else begin
         if (w_enq) begin
            r_wrPtr <= ptrNext(r_wrPtr);
         end
         if (w_deq) begin
            r_rdPtr <= ptrNext(r_rdPtr);
         end
         if (w_enq && !w_deq) begin
            r_count <= r_count + 2'd1;
         end else if (w_deq && !w_enq) begin
            r_count <= r_count - 2'd1;
         end
      end
   end

   // The storage is left unreset; the count alone says which slots hold
   // real entries, so stale data here is never observed. A write during
   // reset is equally harmless because the count is cleared at that edge.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_instMem[r_wrPtr] <= in_inst;
         r_pcMem[r_wrPtr]   <= in_pc;
      end
   end

   // The head slot is presented straight from storage, with no path from
   // in_* so a new entry shows up only after the edge that stores it. An
   // empty buffer shows a NOP at PC 0 so decode sees a clean bubble.
   always_comb begin
      in_ready  = w_inReady;
      out_valid = w_outValid;
      count     = r_count;
      out_inst  = word_width'(NOP_INST);
      out_pc    = '0;
      if (w_outValid) begin
         out_inst = r_instMem[r_rdPtr];
         out_pc   = r_pcMem[r_rdPtr];
      end
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// ----------------------------------------------------------------------------
// tb_if_id_buffer
// Scoreboard bench for if_id_buffer. The reference is a plain queue of
// {inst, pc} entries capped at two; entries it removes are queued as the
// expected decode stream, and a separate monitor compares those against the
// DUT whenever it presents a handshake.
// ----------------------------------------------------------------------------
module tb_if_id_buffer;
   import if_id_buffer_pkg::*;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   typedef struct {
      logic [1:0]  cnt;
      logic        inRdy;
      logic        outVld;
      logic [31:0] inst;
      logic [31:0] pc;
   } status_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_ready;
   logic [1:0]  count;

   entry_t  modelQ[$];
   entry_t  expQ[$];
   status_t statusQ[$];
   bit      modelKnown;

   int tests;
   int fails;

   if_id_buffer #(
      .addr_width(32),
      .word_width(32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_inst  (in_inst),
      .in_pc    (in_pc),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_inst (out_inst),
      .out_pc   (out_pc),
      .out_ready(out_ready),
      .count    (count)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, reports it on a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs just after the falling edge and advances
   // the reference queue by what the upcoming rising edge should do. The
   // status expected before that edge is handed to the monitor first.
   task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                input logic [31:0] inst, input logic [31:0] pc,
                                input logic oR);
      status_t s;
      entry_t  e;
      int      preSize;
      bit      doEnq;
      bit      doDeq;
      @(negedge clk);
      rst       = r;
      flush     = f;
      in_valid  = iv;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = oR;
      preSize   = modelQ.size();
      if (modelKnown) begin
         s.cnt    = 2'(preSize);
         s.inRdy  = (preSize < 2);
         s.outVld = (preSize > 0);
         s.inst   = (preSize > 0) ? modelQ[0].inst : NOP_INST;
         s.pc     = (preSize > 0) ? modelQ[0].pc   : 32'h0;
         statusQ.push_back(s);
      end
      doEnq = iv && (preSize < 2) && !f && !r;
      doDeq = oR && (preSize > 0) && !f && !r;
      if (r || f) begin
         modelQ.delete();
      end else begin
         if (doDeq) expQ.push_back(modelQ.pop_front());
         if (doEnq) begin
            e.inst = inst;
            e.pc   = pc;
            modelQ.push_back(e);
         end
      end
      if (r) modelKnown = 1'b1;
   endtask

   // Monitor: after inputs settle each cycle, checks the status the model
   // predicted and, when the DUT offers a transfer to decode, pops the next
   // expected entry and compares it.
   initial begin
      status_t s;
      entry_t  e;
      forever begin
         @(negedge clk);
         #2;
         if (statusQ.size() > 0) begin
            s = statusQ.pop_front();
            checkOutput("count",     {30'b0, count},     {30'b0, s.cnt});
            checkOutput("in_ready",  {31'b0, in_ready},  {31'b0, s.inRdy});
            checkOutput("out_valid", {31'b0, out_valid}, {31'b0, s.outVld});
            checkOutput("out_inst",  out_inst,  s.inst);
            checkOutput("out_pc",    out_pc,    s.pc);
         end
         if (out_valid === 1'b1 && out_ready && !flush && !rst) begin
            if (expQ.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_deq: got pc %h, expected no transfer", out_pc);
            end else begin
               e = expQ.pop_front();
               checkOutput("deq_inst", out_inst, e.inst);
               checkOutput("deq_pc",   out_pc,   e.pc);
            end
         end
      end
   end

   initial begin
      tests      = 0;
      fails      = 0;
      modelKnown = 1'b0;
      rst        = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      in_inst    = 32'h0;
      in_pc      = 32'h0;
      out_ready  = 1'b0;

      // Reset, then idle.
      applyStimulus(1, 0, 0, 32'h0, 32'h0, 0);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 0);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);

      // Fill with decode stalled; third offer must be dropped; then drain.
      applyStimulus(0, 0, 1, 32'hA000_0001, 32'h00, 0);
      applyStimulus(0, 0, 1, 32'hA000_0002, 32'h04, 0);
      applyStimulus(0, 0, 1, 32'hA000_0003, 32'h08, 0);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 0);

      // Full, offer and drain in the same cycle: only the drain happens.
      applyStimulus(0, 0, 1, 32'hB000_0001, 32'h20, 0);
      applyStimulus(0, 0, 1, 32'hB000_0002, 32'h24, 0);
      applyStimulus(0, 0, 1, 32'hB000_0003, 32'h28, 1);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 0);

      // One entry held, simultaneous enqueue/dequeue repeated past a wrap.
      applyStimulus(0, 0, 1, 32'hC000_0010, 32'h10, 1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 1, 32'hC100_0000 + i, 32'h14 + 4 * i, 1);
      end
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);

      // Full then flush with a concurrent offer.
      applyStimulus(0, 0, 1, 32'hD000_0001, 32'h40, 0);
      applyStimulus(0, 0, 1, 32'hD000_0002, 32'h44, 0);
      applyStimulus(0, 1, 1, 32'hD000_0003, 32'h48, 0);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 0);

      // Full then reset with decode ready.
      applyStimulus(0, 0, 1, 32'hE000_0001, 32'h50, 0);
      applyStimulus(0, 0, 1, 32'hE000_0002, 32'h54, 0);
      applyStimulus(1, 0, 1, 32'hE000_0003, 32'h58, 1);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom % 64) == 0,
                       ($urandom % 16) == 0,
                       ($urandom % 10) < 6,
                       $urandom,
                       {$urandom_range(0, 16383), 2'b00},
                       ($urandom % 10) < 6);
      end
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 0);

      @(negedge clk);
      #5;
      checkOutput("expected_drained", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
